// File: rtl/run_ctrl_pkg.sv
// Shared types and default parameters for the core run controller.
//   state_e   : sequencer states, IDLE -> LOAD -> CRST -> REQ -> RUN -> DONE -> IDLE
//   Def*      : default values for the top-level parameters
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCrst,
    StReq,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DefAw      = 8;
  localparam int unsigned DefCw      = 16;
  localparam int unsigned DefTimeout = 4000;
  localparam int unsigned DefRstHold = 2;
  localparam int unsigned DataW      = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : clear to zero (has priority over inc_i)
//   inc_i         : increment by one, sticking at MAX
//   count_o       : current count
//   at_max_o      : count == MAX
//   near_max_o    : count == MAX-1, i.e. the next increment reaches MAX
module sat_counter #(
  parameter int unsigned W   = 16,
  parameter int unsigned MAX = 4000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         at_max_o,
  output logic         near_max_o
);

  localparam logic [W-1:0] MaxVal  = W'(MAX);
  localparam logic [W-1:0] NearVal = W'(MAX - 1);

  logic [W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MaxVal)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign at_max_o   = (count_q == MaxVal);
  assign near_max_o = (count_q == NearVal);

endmodule

// File: rtl/core_run_ctrl.sv
// Host-side sequencer for one processor core: streams an operand image into data
// memory while the core is held in reset, releases reset, pulses req and times the
// run until core_done or a timeout.
//   clk, reset          : clock, asynchronous active-low reset
//   start               : begin a load+run (honoured in IDLE only)
//   ld_valid/ld_ready   : load-beat handshake; ld_addr/ld_data/ld_last carry the beat
//   busy                : high in every state except IDLE
//   run_done            : one-cycle pulse at the end of a run
//   timeout, cyc_count  : run result, held until the next start
//   core_reset/core_req : active-high reset and one-cycle request to the core
//   core_done           : core finished (only looked at in RUN)
//   dm_wr_en/addr/dat   : registered data-memory write, one per accepted beat
module core_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned AW       = DefAw,
  parameter int unsigned CW       = DefCw,
  parameter int unsigned TIMEOUT  = DefTimeout,
  parameter int unsigned RST_HOLD = DefRstHold
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [AW-1:0]    ld_addr,
  input  logic [DataW-1:0] ld_data,
  input  logic             ld_last,
  output logic             busy,
  output logic             run_done,
  output logic             timeout,
  output logic [CW-1:0]    cyc_count,
  output logic             core_reset,
  output logic             core_req,
  input  logic             core_done,
  output logic             dm_wr_en,
  output logic [AW-1:0]    dm_addr,
  output logic [DataW-1:0] dm_dat
);

  localparam int unsigned HoldW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_HOLD - 1);

  state_e state_d, state_q;

  logic [HoldW-1:0] hold_d, hold_q;
  logic             hold_done;

  logic             core_reset_d, core_reset_q;
  logic             core_req_d, core_req_q;
  logic             run_done_d, run_done_q;
  logic             timeout_d, timeout_q;
  logic             dm_wr_en_d, dm_wr_en_q;
  logic [AW-1:0]    dm_addr_d, dm_addr_q;
  logic [DataW-1:0] dm_dat_d, dm_dat_q;

  logic ld_accept;
  logic cnt_clr, cnt_inc, cnt_at_max, cnt_near_max, run_limit;

  assign ld_ready  = (state_q == StLoad);
  assign busy      = (state_q != StIdle);
  assign ld_accept = ld_ready & ld_valid;

  assign cnt_clr = (state_q == StIdle) & start;
  assign cnt_inc = (state_q == StRun);

  sat_counter #(
    .W   (CW),
    .MAX (TIMEOUT)
  ) u_cyc_cnt (
    .clk_i      (clk),
    .rst_ni     (reset),
    .clr_i      (cnt_clr),
    .inc_i      (cnt_inc),
    .count_o    (cyc_count),
    .at_max_o   (cnt_at_max),
    .near_max_o (cnt_near_max)
  );

  // This RUN cycle's increment brings the count to TIMEOUT.
  assign run_limit = cnt_near_max | cnt_at_max;

  // CRST hold counter: restarts from zero every time CRST is entered.
  assign hold_done = (hold_q == HoldLast);

  always_comb begin
    hold_d = '0;
    if (state_q == StCrst) begin
      hold_d = hold_q + HoldW'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StLoad;
      StLoad: if (ld_valid && ld_last) state_d = StCrst;
      StCrst: if (hold_done) state_d = StReq;
      StReq:  state_d = StRun;
      StRun:  if (core_done || run_limit) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic. Core-side strobes are decoded from the next state so their
  // registered copies line up exactly with the state they belong to.
  always_comb begin
    core_reset_d = !((state_d == StReq) || (state_d == StRun));
    core_req_d   = (state_d == StReq);
    run_done_d   = (state_d == StDone);

    timeout_d = timeout_q;
    if (cnt_clr) begin
      timeout_d = 1'b0;
    end else if ((state_q == StRun) && !core_done && run_limit) begin
      // core_done in the same cycle as the limit counts as a normal finish.
      timeout_d = 1'b1;
    end

    dm_wr_en_d = ld_accept;
    dm_addr_d  = dm_addr_q;
    dm_dat_d   = dm_dat_q;
    if (ld_accept) begin
      dm_addr_d = ld_addr;
      dm_dat_d  = ld_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_reset_q <= 1'b1;
      core_req_q   <= 1'b0;
      run_done_q   <= 1'b0;
      timeout_q    <= 1'b0;
      dm_wr_en_q   <= 1'b0;
      dm_addr_q    <= '0;
      dm_dat_q     <= '0;
    end else begin
      core_reset_q <= core_reset_d;
      core_req_q   <= core_req_d;
      run_done_q   <= run_done_d;
      timeout_q    <= timeout_d;
      dm_wr_en_q   <= dm_wr_en_d;
      dm_addr_q    <= dm_addr_d;
      dm_dat_q     <= dm_dat_d;
    end
  end

  assign core_reset = core_reset_q;
  assign core_req   = core_req_q;
  assign run_done   = run_done_q;
  assign timeout    = timeout_q;
  assign dm_wr_en   = dm_wr_en_q;
  assign dm_addr    = dm_addr_q;
  assign dm_dat     = dm_dat_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Randomised scoreboard bench for core_run_ctrl (TIMEOUT reduced to 50).
module tb_core_run_ctrl;

  localparam int unsigned AW = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned TO = 50;
  localparam int unsigned RH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [7:0]    ld_data = '0;
  logic          ld_last = 1'b0;
  logic          core_done = 1'b0;
  logic          ld_ready, busy, run_done, timeout, core_reset, core_req, dm_wr_en;
  logic [CW-1:0] cyc_count;
  logic [AW-1:0] dm_addr;
  logic [7:0]    dm_dat;

  always #5 clk = ~clk;

  core_run_ctrl #(
    .AW       (AW),
    .CW       (CW),
    .TIMEOUT  (TO),
    .RST_HOLD (RH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .busy       (busy),
    .run_done   (run_done),
    .timeout    (timeout),
    .cyc_count  (cyc_count),
    .core_reset (core_reset),
    .core_req   (core_req),
    .core_done  (core_done),
    .dm_wr_en   (dm_wr_en),
    .dm_addr    (dm_addr),
    .dm_dat     (dm_dat)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  typedef struct packed {
    logic          to;
    logic [CW-1:0] cnt;
  } res_t;

  wr_t  exp_wr[$];
  res_t exp_res[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT presents a write or a result.
  logic acc_prev = 1'b0;
  logic req_prev = 1'b0;
  logic done_prev = 1'b0;
  int   req_cnt = 0;
  wr_t  mon_w;
  res_t mon_r;

  always @(negedge clk) begin
    if (!reset) begin
      acc_prev  = 1'b0;
      req_prev  = 1'b0;
      done_prev = 1'b0;
      req_cnt   = 0;
    end else begin
      if (dm_wr_en || acc_prev) check("dm_wr_latency", dm_wr_en, acc_prev);
      if (dm_wr_en) begin
        check("dm_wr_pending", exp_wr.size() > 0, 1);
        if (exp_wr.size() > 0) begin
          mon_w = exp_wr.pop_front();
          check("dm_addr", dm_addr, mon_w.addr);
          check("dm_dat", dm_dat, mon_w.data);
        end
      end
      acc_prev = ld_valid && ld_ready;

      if (core_req) begin
        req_cnt++;
        check("core_req_width", req_prev, 0);
        check("core_reset_in_req", core_reset, 0);
      end
      req_prev = core_req;

      if (run_done) begin
        check("run_done_width", done_prev, 0);
        check("core_reset_at_done", core_reset, 1);
        check("reqs_per_run", req_cnt, 1);
        req_cnt = 0;
        check("result_pending", exp_res.size() > 0, 1);
        if (exp_res.size() > 0) begin
          mon_r = exp_res.pop_front();
          check("timeout", timeout, mon_r.to);
          check("cyc_count", cyc_count, mon_r.cnt);
        end
      end
      done_prev = run_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_core_reset", core_reset, 1);
    check("rst_core_req", core_req, 0);
    check("rst_cyc_count", cyc_count, 0);
    check("rst_timeout", timeout, 0);
    check("rst_run_done", run_done, 0);
    check("rst_dm_wr_en", dm_wr_en, 0);
    check("rst_ld_ready", ld_ready, 0);
    exp_wr.delete();
    ld_valid  = 1'b0;
    ld_last   = 1'b0;
    start     = 1'b0;
    core_done = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_idle", busy, 0);
    check("post_rst_core_reset", core_reset, 1);
  endtask

  // One load+run. d = RUN cycle on which the core reports done (0 = never).
  // abort: 0 none, 1 reset in LOAD after second beat, 2 reset in RUN.
  task automatic run_once(input int nb, input bit fixed_img, input int d, input int abort);
    logic [7:0]    tbl [3];
    logic [AW-1:0] a;
    logic [7:0]    v;
    int            cnt;
    res_t          r;
    tbl = '{8'hAA, 8'hBB, 8'hCC};

    core_done = 1'($urandom_range(0, 1));  // stale done must be ignored
    repeat ($urandom_range(0, 2)) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ld_ready_in_load", ld_ready, 1);

    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, 2)) begin
        start = 1'($urandom_range(0, 1));    // ignored in LOAD
        tick();
      end
      start = 1'b0;
      if (fixed_img) begin
        a = AW'(8'h10 + i);
        v = tbl[i];
      end else begin
        a = AW'($urandom);
        v = 8'($urandom);
      end
      ld_valid = 1'b1;
      ld_addr  = a;
      ld_data  = v;
      ld_last  = (i == nb - 1);
      if (!(abort == 1 && i == 1)) exp_wr.push_back('{addr: a, data: v});
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      if (abort == 1 && i == 1) begin
        do_reset();
        return;
      end
    end

    cnt = 0;
    while (!core_req && cnt < 20) begin
      tick();
      cnt++;
    end
    check("req_reached", core_req, 1);
    check("crst_hold_cycles", cnt, RH);
    core_done = 1'b0;

    if (d >= 1 && d <= int'(TO)) r = '{to: 1'b0, cnt: CW'(d)};
    else r = '{to: 1'b1, cnt: CW'(TO)};
    if (abort == 0) exp_res.push_back(r);

    for (int k = 1; k <= int'(TO) + 5; k++) begin
      tick();
      if (run_done) break;
      core_done = (k == d);
      start     = (k == 1);      // ignored in RUN
      if (abort == 2 && k == 10) begin
        do_reset();
        return;
      end
    end
    check("run_done_seen", run_done, 1);
    core_done = 1'b0;
    start     = 1'b0;
    tick();
    check("idle_after_done", busy, 0);
    check("core_reset_after_done", core_reset, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("init_busy", busy, 0);
    check("init_core_reset", core_reset, 1);
    check("init_core_req", core_req, 0);
    check("init_cyc_count", cyc_count, 0);
    check("init_dm_wr_en", dm_wr_en, 0);
    reset = 1'b1;
    tick();

    run_once(3, 1'b1, 37, 0);  // directed image, normal run
    run_once(2, 1'b0, 0, 0);   // timeout
    run_once(1, 1'b0, 50, 0);  // done on the limit cycle
    run_once(3, 1'b0, 51, 0);  // done just too late
    run_once(2, 1'b0, 1, 0);
    run_once(2, 1'b0, 49, 0);
    run_once(4, 1'b0, 0, 1);   // reset mid-LOAD
    run_once(2, 1'b0, 0, 2);   // reset mid-RUN
    for (int n = 0; n < 12; n++) begin
      run_once(int'($urandom_range(1, 5)), 1'b0, int'($urandom_range(0, 60)), 0);
    end

    repeat (3) tick();
    check("exp_wr_drained", exp_wr.size(), 0);
    check("exp_res_drained", exp_res.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
